// File: rtl/rdi_bring_up_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rdi_bring_up_engine                                                          |
// | RDI sideband bring-up: requester and responder FSMs sharing one TX port.     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module rdi_bring_up_engine #(
  parameter int         MSG_W       = 4,
  parameter int         RSP_BIT     = 3,
  parameter int         TIMEOUT_CYC = 1000,
  parameter int         MAX_RETRY   = 3,
  parameter logic [3:0] LP_REQ_CODE = 4'h1
) (
  input  logic             lclk,
  input  logic             sys_rst,
  input  logic             i_start,
  input  logic [MSG_W-1:0] i_mode,
  input  logic [3:0]       i_lp_state_req,
  input  logic             i_rx_msg_valid,
  input  logic [MSG_W-1:0] i_rx_sb_message,
  input  logic             i_tx_done,
  output logic [MSG_W-1:0] o_tx_sb_message,
  output logic             o_tx_msg_valid,
  output logic             o_done,
  output logic             o_error,
  output logic [((MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1)-1:0] o_retry_cnt
);

  localparam int c_TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int c_RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [MSG_W-1:0] c_RSP_MASK  = MSG_W'(1) << RSP_BIT;
  localparam logic [c_TW-1:0]  c_TMO_LAST  = c_TW'(TIMEOUT_CYC - 1);
  localparam logic [c_RW-1:0]  c_MAX_RETRY = c_RW'(MAX_RETRY);

  localparam logic [2:0] c_RQ_IDLE = 3'd0;
  localparam logic [2:0] c_RQ_SEND = 3'd1;
  localparam logic [2:0] c_RQ_WAIT = 3'd2;
  localparam logic [2:0] c_RQ_DONE = 3'd3;
  localparam logic [2:0] c_RQ_ERR  = 3'd4;

  localparam logic [1:0] c_RS_IDLE = 2'd0;
  localparam logic [1:0] c_RS_PEND = 2'd1;
  localparam logic [1:0] c_RS_SEND = 2'd2;
  localparam logic [1:0] c_RS_DONE = 2'd3;

  localparam logic [1:0] c_OWN_NONE = 2'd0;
  localparam logic [1:0] c_OWN_REQ  = 2'd1;
  localparam logic [1:0] c_OWN_RSP  = 2'd2;

  logic [2:0]       r_rq_state, w_rq_nxt;
  logic [1:0]       r_rs_state, w_rs_nxt;
  logic [1:0]       r_owner, w_own;
  logic [c_TW-1:0]  r_timer;
  logic [c_RW-1:0]  r_retry;
  logic             r_done, r_error;
  logic [MSG_W-1:0] w_rsp_code;
  logic             w_rx_rsp, w_rx_req, w_tmo, w_tx_req_done, w_tx_rsp_done;

  assign w_rsp_code    = i_mode | c_RSP_MASK;
  assign w_rx_rsp      = i_rx_msg_valid && (i_rx_sb_message == w_rsp_code);
  assign w_rx_req      = i_rx_msg_valid && (i_rx_sb_message == i_mode);
  assign w_tmo         = (r_timer == c_TMO_LAST);
  assign w_tx_req_done = i_tx_done && (w_own == c_OWN_REQ);
  assign w_tx_rsp_done = i_tx_done && (w_own == c_OWN_RSP);

  // A free port is granted in the same cycle; a pending response beats a request.
  always_comb begin
    w_own = r_owner;
    if (r_owner == c_OWN_NONE) begin
      if (r_rs_state == c_RS_SEND)      w_own = c_OWN_RSP;
      else if (r_rq_state == c_RQ_SEND) w_own = c_OWN_REQ;
    end
  end

  always_ff @(posedge lclk) begin
    if (sys_rst) begin
      r_rq_state <= c_RQ_IDLE;
      r_rs_state <= c_RS_IDLE;
      r_owner    <= c_OWN_NONE;
    end else begin
      r_rq_state <= w_rq_nxt;
      r_rs_state <= w_rs_nxt;
      r_owner    <= (!i_start || i_tx_done) ? c_OWN_NONE : w_own;
    end
  end

  always_comb begin
    w_rq_nxt = r_rq_state;
    if (!i_start) begin
      w_rq_nxt = c_RQ_IDLE;
    end else begin
      case (r_rq_state)
        c_RQ_IDLE: w_rq_nxt = c_RQ_SEND;
        c_RQ_SEND: if (w_tx_req_done) w_rq_nxt = c_RQ_WAIT;
        c_RQ_WAIT: begin
          if (w_rx_rsp)   w_rq_nxt = c_RQ_DONE;
          else if (w_tmo) w_rq_nxt = (r_retry < c_MAX_RETRY) ? c_RQ_SEND : c_RQ_ERR;
        end
        c_RQ_DONE, c_RQ_ERR: w_rq_nxt = r_rq_state;
        default:   w_rq_nxt = c_RQ_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rs_nxt = r_rs_state;
    if (!i_start) begin
      w_rs_nxt = c_RS_IDLE;
    end else begin
      case (r_rs_state)
        c_RS_IDLE, c_RS_DONE: if (w_rx_req) w_rs_nxt = c_RS_PEND;
        c_RS_PEND: if (i_lp_state_req == LP_REQ_CODE) w_rs_nxt = c_RS_SEND;
        c_RS_SEND: if (w_tx_rsp_done) w_rs_nxt = c_RS_DONE;
        default:   w_rs_nxt = c_RS_IDLE;
      endcase
    end
  end

  always_comb begin
    o_tx_msg_valid  = 1'b0;
    o_tx_sb_message = '0;
    case (w_own)
      c_OWN_REQ: begin
        o_tx_msg_valid  = 1'b1;
        o_tx_sb_message = i_mode;
      end
      c_OWN_RSP: begin
        o_tx_msg_valid  = 1'b1;
        o_tx_sb_message = w_rsp_code;
      end
      default: ;
    endcase
  end

  // Timer restarts on every entry into WAIT_RSP.
  always_ff @(posedge lclk) begin
    if (sys_rst) begin
      r_timer <= '0;
      r_retry <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_timer <= ((r_rq_state == c_RQ_WAIT) && (w_rq_nxt == c_RQ_WAIT)) ? r_timer + 1'b1 : '0;
      if (!i_start)
        r_retry <= '0;
      else if ((r_rq_state == c_RQ_WAIT) && (w_rq_nxt == c_RQ_SEND))
        r_retry <= r_retry + 1'b1;
      r_done  <= i_start && (r_rq_state == c_RQ_DONE) && (r_rs_state == c_RS_DONE);
      r_error <= i_start && (r_error || (w_rq_nxt == c_RQ_ERR));
    end
  end

  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_retry_cnt = r_retry;

endmodule
`default_nettype wire
